// File: rtl/secuenciador_op_pkg.sv
// Shared definitions for the operation sequencer: FSM state encoding and operation codes.
// The optional guard cycle is selected with the macro SECUENCIADOR_OP_GUARDA_EN.
package secuenciador_op_pkg;

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        EJECUTA = 2'd1,
        GUARDA  = 2'd2
    } estado_t;

    localparam logic [1:0] OP_0 = 2'b00;
    localparam logic [1:0] OP_1 = 2'b01;
    localparam logic [1:0] OP_2 = 2'b10;
    localparam logic [1:0] OP_3 = 2'b11;

endpackage

// File: rtl/secuenciador_op_fifo_cmd.sv
// Command FIFO: PROF entries of ANCHO bits, head readable combinationally, no bypass.
// Push when full and pop when empty are ignored, so occupancy always stays in 0..PROF.
module fifo_cmd #(
    parameter int PROF  = 4,
    parameter int ANCHO = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [ANCHO-1:0]       dato_push,
    input  logic                   pop,
    output logic [ANCHO-1:0]       dato_cab,
    output logic [$clog2(PROF):0]  cuenta,
    output logic                   lleno,
    output logic                   vacio
);
    localparam int PW = $clog2(PROF);
    localparam logic [PW:0] CUENTA_MAX = (PW+1)'(PROF);

    logic [ANCHO-1:0] mem [PROF];
    logic [PW-1:0]    ptr_esc;
    logic [PW-1:0]    ptr_lec;
    logic             push_ok;
    logic             pop_ok;

    assign lleno    = (cuenta == CUENTA_MAX);
    assign vacio    = (cuenta == '0);
    assign push_ok  = push && !lleno;
    assign pop_ok   = pop && !vacio;
    assign dato_cab = mem[ptr_lec];

    // Pointers are PW bits wide, so they wrap modulo PROF on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_esc <= '0;
            ptr_lec <= '0;
            cuenta  <= '0;
        end else begin
            if (push_ok) ptr_esc <= ptr_esc + 1'b1;
            if (pop_ok)  ptr_lec <= ptr_lec + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cuenta <= cuenta + 1'b1;
                2'b01:   cuenta <= cuenta - 1'b1;
                default: cuenta <= cuenta;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[ptr_esc] <= dato_push;
    end

endmodule

// File: rtl/secuenciador_op.sv
// Operation sequencer: queues {op, dur} commands and drives a registered op/enable pair.
// Macro SECUENCIADOR_OP_GUARDA_EN inserts a one-cycle disabled guard after every command.
module secuenciador_op
    import secuenciador_op_pkg::*;
#(
    parameter int PROF  = 4,
    parameter int DUR_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             ent_op,
    input  logic [DUR_W-1:0]       ent_dur,
    input  logic                   ent_valido,
    output logic                   ent_listo,
    output logic [1:0]             sal_op,
    output logic                   sal_en,
    output logic                   ocupado,
    output logic [$clog2(PROF):0]  cuenta
);
    localparam int ANCHO = 2 + DUR_W;

    logic [ANCHO-1:0] dato_cab;
    logic [1:0]       cab_op;
    logic [DUR_W-1:0] cab_dur;
    logic [DUR_W-1:0] dur_cab;
    logic             lleno;
    logic             vacio;
    logic             pop;
    logic             cargar;

    estado_t          estado, estado_sig;
    logic [DUR_W-1:0] cnt, cnt_sig;
    logic [1:0]       op_act, op_act_sig;

    fifo_cmd #(.PROF(PROF), .ANCHO(ANCHO)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ent_valido && ent_listo),
        .dato_push ({ent_op, ent_dur}),
        .pop       (pop),
        .dato_cab  (dato_cab),
        .cuenta    (cuenta),
        .lleno     (lleno),
        .vacio     (vacio)
    );

    assign ent_listo = !lleno;
    assign cab_op    = dato_cab[ANCHO-1 -: 2];
    assign cab_dur   = dato_cab[DUR_W-1:0];
    assign dur_cab   = (cab_dur == '0) ? DUR_W'(1) : cab_dur;
    assign ocupado   = (estado != REPOSO) || !vacio || sal_en;

    always_comb begin
        estado_sig = estado;
        cnt_sig    = cnt;
        op_act_sig = op_act;
        cargar     = 1'b0;
        pop        = 1'b0;
        case (estado)
            REPOSO: begin
                if (!vacio) cargar = 1'b1;
            end
            EJECUTA: begin
                if (cnt > DUR_W'(1)) begin
                    cnt_sig = cnt - 1'b1;
                end else begin
`ifdef SECUENCIADOR_OP_GUARDA_EN
                    cnt_sig    = '0;
                    estado_sig = GUARDA;
`else
                    if (!vacio) begin
                        cargar = 1'b1;
                    end else begin
                        cnt_sig    = '0;
                        estado_sig = REPOSO;
                    end
`endif
                end
            end
            GUARDA: begin
`ifdef SECUENCIADOR_OP_GUARDA_EN
                // The guard cycle itself is the only sal_en gap; a waiting command starts right after it.
                if (!vacio) cargar = 1'b1;
                else        estado_sig = REPOSO;
`else
                estado_sig = REPOSO;
`endif
            end
            default: estado_sig = REPOSO;
        endcase
        if (cargar) begin
            pop        = 1'b1;
            op_act_sig = cab_op;
            cnt_sig    = dur_cab;
            estado_sig = EJECUTA;
        end
    end

    // sal_en/sal_op mirror the previous EJECUTA cycle, giving the two-cycle start latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= REPOSO;
            cnt    <= '0;
            op_act <= OP_0;
            sal_op <= OP_0;
            sal_en <= 1'b0;
        end else begin
            estado <= estado_sig;
            cnt    <= cnt_sig;
            op_act <= op_act_sig;
            sal_en <= (estado == EJECUTA);
            if (estado == EJECUTA) sal_op <= op_act;
        end
    end

endmodule

// File: tb/tb_secuenciador_op.sv
// Self-checking bench for secuenciador_op: directed scenarios plus random traffic,
// checked every cycle against a command-timeline reference model.
module tb_secuenciador_op;

    localparam int PROF  = 4;
    localparam int DUR_W = 4;
    localparam int CW    = $clog2(PROF) + 1;
`ifdef SECUENCIADOR_OP_GUARDA_EN
    localparam int HUECO = 1;
    localparam int CUENTA_035 = 3;
`else
    localparam int HUECO = 0;
    localparam int CUENTA_035 = 2;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ent_op;
    logic [DUR_W-1:0] ent_dur;
    logic             ent_valido;
    logic             ent_listo;
    logic [1:0]       sal_op;
    logic             sal_en;
    logic             ocupado;
    logic [CW-1:0]    cuenta;

    always #5 clk = ~clk;

    secuenciador_op #(.PROF(PROF), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ent_op     (ent_op),
        .ent_dur    (ent_dur),
        .ent_valido (ent_valido),
        .ent_listo  (ent_listo),
        .sal_op     (sal_op),
        .sal_en     (sal_en),
        .ocupado    (ocupado),
        .cuenta     (cuenta)
    );

    // ---------------- reference model ----------------
    // Each accepted command becomes an interval [start, end) of edges during which sal_en
    // must be high; it leaves the FIFO on edge start-1.
    int         t = 0;
    int         checks = 0;
    int         failures = 0;
    int         n_en_alto = 0;
    logic       aceptado = 1'b0;
    int         m_acc[$];
    int         m_start[$];
    int         m_end[$];
    int         m_op[$];
    int         ult_fin = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int m_cuenta(input int x);
        int c = 0;
        foreach (m_acc[i]) begin
            if (m_acc[i] <= x)       c++;
            if (m_start[i] - 1 <= x) c--;
        end
        return c;
    endfunction

    function automatic int m_en(input int x);
        foreach (m_start[i])
            if (m_start[i] <= x && x < m_end[i]) return 1;
        return 0;
    endfunction

    function automatic int m_op_at(input int x);
        int r = 0;
        foreach (m_start[i])
            if (m_start[i] <= x) r = m_op[i];
        return r;
    endfunction

    function automatic int m_ocup(input int x);
        if (m_cuenta(x) > 0) return 1;
        foreach (m_start[i])
            if (m_start[i] - 1 <= x && x < m_end[i]) return 1;
        return 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic paso();
        int c_prev, s, d;
        @(posedge clk);
        t++;
        aceptado = 1'b0;
        if (rst) begin
            m_acc.delete(); m_start.delete(); m_end.delete(); m_op.delete();
            exp_q.delete();
            ult_fin = 0;
        end else begin
            c_prev = m_cuenta(t - 1);
            if (ent_valido && c_prev < PROF) begin
                d = (ent_dur == '0) ? 1 : int'(ent_dur);
                s = (t + 2 > ult_fin + HUECO) ? t + 2 : ult_fin + HUECO;
                m_acc.push_back(t);
                m_start.push_back(s);
                m_end.push_back(s + d);
                m_op.push_back(int'(ent_op));
                exp_q.push_back(ent_op);
                ult_fin  = s + d;
                aceptado = 1'b1;
            end
        end
        #1;
        if (sal_en) n_en_alto++;
        check("sal_en",    int'(sal_en),    m_en(t));
        check("sal_op",    int'(sal_op),    m_op_at(t));
        check("cuenta",    int'(cuenta),    m_cuenta(t));
        check("ent_listo", int'(ent_listo), int'(m_cuenta(t) < PROF));
        check("ocupado",   int'(ocupado),   m_ocup(t));
        // scoreboard: each new sal_en period must carry the next command in acceptance order
        foreach (m_start[i]) begin
            if (m_start[i] == t && exp_q.size() > 0) check("orden_op", int'(sal_op), int'(exp_q.pop_front()));
        end
    endtask

    task automatic esperar(input int n);
        repeat (n) paso();
    endtask

    task automatic enviar(input logic [1:0] op, input logic [DUR_W-1:0] d);
        int n = 0;
        ent_op     = op;
        ent_dur    = d;
        ent_valido = 1'b1;
        do begin
            paso();
            n++;
        end while (!aceptado && n < 200);
        if (!aceptado) check("timeout_enviar", 0, 1);
        ent_valido = 1'b0;
        ent_op     = 2'($urandom);
        ent_dur    = DUR_W'($urandom);
    endtask

    task automatic reiniciar();
        ent_valido = 1'b0;
        rst = 1'b1;
        esperar(2);
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst        = 1'b1;
        ent_valido = 1'b0;
        ent_op     = 2'b00;
        ent_dur    = '0;

        reiniciar();
        check("reset_sal_en", int'(sal_en), 0);
        check("reset_cuenta", int'(cuenta), 0);
        esperar(1);
        check("listo_tras_reset", int'(ent_listo), 1);

        // {10,3}: three enable cycles with op 10, then idle
        n_en_alto = 0;
        enviar(2'b10, 4'd3);
        esperar(8);
        check("req030_ciclos_en", n_en_alto, 3);
        check("req030_ocupado", int'(ocupado), 0);

        // dur=0 behaves as one cycle
        n_en_alto = 0;
        enviar(2'b01, 4'd0);
        esperar(6);
        check("req031_ciclos_en", n_en_alto, 1);

        // five pushes into a depth-4 FIFO; the fifth waits for the first pop
        n_en_alto = 0;
        for (int i = 0; i < 5; i++) enviar(2'(i), 4'd2);
        esperar(20);
        check("req032_ciclos_en", n_en_alto, 10);

        // two queued 2-cycle commands run back to back
        n_en_alto = 0;
        enviar(2'b00, 4'd2);
        enviar(2'b11, 4'd2);
        esperar(10);
        check("req033_ciclos_en", n_en_alto, 4);

        // reset in the second enable cycle of a dur=5 command with two queued
        enviar(2'b00, 4'd5);
        enviar(2'b01, 4'd2);
        enviar(2'b10, 4'd2);
        n = 0;
        while (!sal_en && n < 20) begin
            paso();
            n++;
        end
        check("req034_arranque", int'(sal_en), 1);
        paso();
        rst = 1'b1;
        paso();
        rst = 1'b0;
        check("req034_sal_en", int'(sal_en), 0);
        check("req034_cuenta", int'(cuenta), 0);
        n_en_alto = 0;
        esperar(15);
        check("req034_sin_en", n_en_alto, 0);

        // push and pop on the same edge with two entries queued
        enviar(2'b00, 4'd3);
        enviar(2'b01, 4'd1);
        enviar(2'b10, 4'd1);
        esperar(1);
        check("req035_antes", int'(cuenta), 2);
        enviar(2'b11, 4'd1);
        check("req035_cuenta", int'(cuenta), CUENTA_035);
        esperar(12);

        // random traffic with a source that holds until accepted, plus one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                rst        = 1'b1;
                ent_valido = 1'b0;
            end else begin
                rst = 1'b0;
                if (!ent_valido || aceptado) begin
                    ent_valido = ($urandom_range(0, 2) != 0);
                    ent_op     = 2'($urandom);
                    ent_dur    = DUR_W'($urandom_range(0, 4));
                end
            end
            paso();
        end
        rst        = 1'b0;
        ent_valido = 1'b0;
        esperar(40);
        check("final_ocupado", int'(ocupado), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
